// File: rtl/sisc_mem_arb_pkg.sv
// sisc_mem_arb_pkg: shared state encoding and sizing helper for the SISC memory arbiter.
package sisc_mem_arb_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/sisc_arb_pick.sv
// sisc_arb_pick: winner select between fetch and data, with a starvation streak counter.
module sisc_arb_pick
   import sisc_mem_arb_pkg::*;
#(
   parameter int STARVE = 4
) (
   input  logic clk,
   input  logic rst_f,
   input  logic if_req,
   input  logic dm_req,
   input  logic grant,
   output logic sel_dm
);
   localparam int SW = cnt_w(STARVE);
   logic [SW-1:0] streak;
   logic starved;
   assign starved = if_req && (streak == SW'(STARVE));
   assign sel_dm  = dm_req && !starved;
   // A data grant under contention can never happen while starved, so +1 never overflows.
   always_ff @(posedge clk or posedge rst_f)
      if (rst_f) streak <= '0;
      else if (grant) streak <= !sel_dm ? '0 : if_req ? streak + SW'(1) : streak;
endmodule

// File: rtl/sisc_mem_arb.sv
// sisc_mem_arb: single-port memory arbiter sharing one synchronous memory
// between instruction fetch and LOD/STR data accesses.
module sisc_mem_arb
   import sisc_mem_arb_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int MEM_LAT = 2,
   parameter int STARVE  = 4
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_ack,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);
   localparam int CW = cnt_w(MEM_LAT);
   state_t state, state_nx;
   logic own_dm, we_q, sel_dm, grant;
   logic [CW-1:0] cnt;
   assign grant = (state == IDLE) && (if_req || dm_req);
   sisc_arb_pick #(.STARVE(STARVE)) u_pick (
      .clk    (clk),
      .rst_f  (rst_f),
      .if_req (if_req),
      .dm_req (dm_req),
      .grant  (grant),
      .sel_dm (sel_dm)
   );
   always_ff @(posedge clk or posedge rst_f)
      if (rst_f) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state == IDLE  ? (grant ? ISSUE : IDLE)
               : state == ISSUE ? (we_q ? ACK : WAIT)
               : state == WAIT  ? (cnt == CW'(1) ? ACK : WAIT)
               : IDLE;
      mem_en   = state == ISSUE;
      mem_we   = (state == ISSUE) && we_q;
      if_ack   = (state == ACK) && !own_dm;
      dm_ack   = (state == ACK) && own_dm;
      busy     = state != IDLE;
   end
   // The memory port is driven only from these latched copies, never from the requesters.
   always_ff @(posedge clk or posedge rst_f)
      if (rst_f) begin
         own_dm    <= 1'b0;
         we_q      <= 1'b0;
         cnt       <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         if (grant) begin
            own_dm   <= sel_dm;
            mem_addr <= sel_dm ? dm_addr : if_addr;
            we_q     <= sel_dm && dm_we;
            if (sel_dm) mem_wdata <= dm_wdata;
         end
         if (state == ISSUE) cnt <= CW'(MEM_LAT);
         if (state == WAIT) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               if (own_dm) dm_rdata <= mem_rdata;
               else if_rdata <= mem_rdata;
            end
         end
      end
endmodule

// File: tb/tb_sisc_mem_arb.sv
// tb_sisc_mem_arb: vector table, directed corner sequences and randomized traffic
// for sisc_mem_arb, checked against a memory-array model and the grant rules.
module tb_sisc_mem_arb;
   import sisc_mem_arb_pkg::*;
   localparam int LAT = 2;
   localparam int STARVE = 4;

   logic clk = 1'b0;
   logic rst_f = 1'b1;
   logic init_mem = 1'b1;
   always #5 clk = ~clk;

   logic if_req = 0, dm_req = 0, dm_we = 0;
   logic [15:0] if_addr = 0, dm_addr = 0;
   logic [31:0] dm_wdata = 0;
   logic if_ack, dm_ack, mem_en, mem_we, busy;
   logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic [15:0] mem_addr;

   logic if_req1 = 0, dm_req1 = 0;
   logic [15:0] if_addr1 = 0, dm_addr1 = 0;
   logic if_ack1, dm_ack1, mem_en1, mem_we1, busy1;
   logic [31:0] if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;
   logic [15:0] mem_addr1;

   sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(LAT), .STARVE(STARVE)) dut (
      .clk(clk), .rst_f(rst_f),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(1), .STARVE(STARVE)) dut1 (
      .clk(clk), .rst_f(rst_f),
      .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1),
      .dm_req(dm_req1), .dm_we(1'b0), .dm_addr(dm_addr1), .dm_wdata(32'h0),
      .dm_ack(dm_ack1), .dm_rdata(dm_rdata1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .busy(busy1)
   );

   function automatic logic [31:0] init_val(input int i);
      return (i == 16) ? 32'hDEADBEEF : (32'hA5000000 | i);
   endfunction

   // Synchronous memories: data appears exactly LAT cycles after the mem_en cycle, zero otherwise.
   logic [31:0] phys [0:255];
   logic [31:0] phys1 [0:255];
   logic [31:0] rd_pipe [0:LAT-1];
   logic [31:0] rd1;
   assign mem_rdata  = rd_pipe[LAT-1];
   assign mem_rdata1 = rd1;
   always @(posedge clk) begin
      if (init_mem)
         for (int i = 0; i < 256; i++) begin
            phys[i]  <= init_val(i);
            phys1[i] <= init_val(i);
         end
      else if (mem_en && mem_we) phys[mem_addr[7:0]] <= mem_wdata;
      rd_pipe[0] <= (mem_en && !mem_we) ? phys[mem_addr[7:0]] : 32'h0;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      rd1 <= (mem_en1 && !mem_we1) ? phys1[mem_addr1[7:0]] : 32'h0;
   end

   logic [31:0] mdl [0:255];
   int nvec = 0;
   int nbad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Grant-rule monitor: the winner is decided from the requests seen in the cycle before mem_en.
   logic p_if = 0, p_dm = 0, p_we = 0;
   logic [15:0] p_ia = 0, p_da = 0;
   int m_streak = 0;
   bit pd;
   always @(negedge clk) begin
      if (rst_f) m_streak = 0;
      else begin
         if (mem_en) begin
            pd = p_dm && !(p_if && m_streak == STARVE);
            chk("grant_addr", {16'h0, mem_addr}, {16'h0, pd ? p_da : p_ia});
            chk("grant_we", {31'h0, mem_we}, {31'h0, pd && p_we});
            m_streak = !pd ? 0 : p_if ? m_streak + 1 : m_streak;
         end
         if (if_ack || dm_ack) chk("ack_excl", {31'h0, if_ack && dm_ack}, 32'h0);
      end
      p_if = if_req; p_dm = dm_req; p_we = dm_we; p_ia = if_addr; p_da = dm_addr;
   end

   typedef struct {
      bit          dm;
      bit          we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic do_txn(input vec_t v);
      bit got;
      got = 0;
      @(posedge clk); #1;
      if (v.dm) begin
         dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
         if_req = 1; if_addr = v.addr;
      end
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (c == 0) chk("idle_busy", {31'h0, busy}, 32'h0);
         if (c == 1) begin
            chk("issue_en", {31'h0, mem_en}, 32'h1);
            chk("issue_addr", {16'h0, mem_addr}, {16'h0, v.addr});
            chk("issue_we", {31'h0, mem_we}, {31'h0, v.we});
         end
         if (v.dm ? dm_ack : if_ack) begin
            got = 1;
            chk("ack_cycle", c, v.lat);
            if (!v.we) chk("rdata", v.dm ? dm_rdata : if_rdata, v.exp);
            chk("other_ack", {31'h0, v.dm ? if_ack : dm_ack}, 32'h0);
         end
      end
      chk("ack_seen", {31'h0, got}, 32'h1);
      @(posedge clk); #1;
      if_req = 0; dm_req = 0; dm_we = 0;
      @(negedge clk);
      chk("ack_pulse", {31'h0, if_ack | dm_ack}, 32'h0);
      if (v.we) mdl[v.addr[7:0]] = v.wdata;
   endtask

   task automatic do_txn1(input bit dm, input logic [15:0] a);
      bit got;
      got = 0;
      @(posedge clk); #1;
      if (dm) begin dm_req1 = 1; dm_addr1 = a; end
      else begin if_req1 = 1; if_addr1 = a; end
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (c == 1) chk("lat1_en", {31'h0, mem_en1}, 32'h1);
         if (dm ? dm_ack1 : if_ack1) begin
            got = 1;
            chk("lat1_ack_cycle", c, 3);
            chk("lat1_rdata", dm ? dm_rdata1 : if_rdata1, init_val(int'(a[7:0])));
         end
      end
      chk("lat1_ack_seen", {31'h0, got}, 32'h1);
      @(posedge clk); #1;
      if_req1 = 0; dm_req1 = 0;
   endtask

   task automatic rand_if(input int n);
      bit got;
      logic [15:0] a;
      for (int k = 0; k < n; k++) begin
         got = 0;
         @(posedge clk);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         a = 16'($urandom_range(0, 15));
         if_req = 1; if_addr = a;
         for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (if_ack) begin
               got = 1;
               chk("rand_if_rdata", if_rdata, mdl[a[7:0]]);
            end
         end
         chk("rand_if_seen", {31'h0, got}, 32'h1);
         @(posedge clk); #1;
         if_req = 0;
      end
   endtask

   task automatic rand_dm(input int n);
      bit got, w;
      logic [15:0] a;
      logic [31:0] d;
      for (int k = 0; k < n; k++) begin
         got = 0;
         @(posedge clk);
         repeat ($urandom_range(0, 1)) @(posedge clk);
         #1;
         a = 16'($urandom_range(0, 15));
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         dm_req = 1; dm_we = w; dm_addr = a; dm_wdata = d;
         for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (dm_ack) begin
               got = 1;
               if (w) mdl[a[7:0]] = d;
               else chk("rand_dm_rdata", dm_rdata, mdl[a[7:0]]);
            end
         end
         chk("rand_dm_seen", {31'h0, got}, 32'h1);
         @(posedge clk); #1;
         dm_req = 0; dm_we = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   vec_t tbl [8];
   int owners [10];
   int nack;
   bit saw_ack;
   vec_t v;
   initial begin
      for (int i = 0; i < 256; i++) mdl[i] = init_val(i);
      tbl[0] = '{0, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 4};
      tbl[1] = '{1, 1, 16'h0020, 32'h12345678, 32'h0, 2};
      tbl[2] = '{1, 0, 16'h0020, 32'h0, 32'h12345678, 4};
      tbl[3] = '{0, 0, 16'h0020, 32'h0, 32'h12345678, 4};
      tbl[4] = '{1, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 4};
      tbl[5] = '{1, 1, 16'h0030, 32'hCAFEF00D, 32'h0, 2};
      tbl[6] = '{0, 0, 16'h0031, 32'h0, 32'hA5000031, 4};
      tbl[7] = '{1, 0, 16'h0030, 32'h0, 32'hCAFEF00D, 4};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
      chk("rst_acks", {30'h0, if_ack, dm_ack}, 32'h0);
      chk("rst_addr", {16'h0, mem_addr}, 32'h0);
      chk("rst_rdata", if_rdata | dm_rdata | mem_wdata, 32'h0);
      @(posedge clk); #1;
      rst_f = 0; init_mem = 0;

      foreach (tbl[i]) do_txn(tbl[i]);

      // Both requesters hold req high: four data grants, then fetch is forced.
      @(posedge clk); #1;
      if_req = 1; if_addr = 16'h0040; dm_req = 1; dm_we = 0; dm_addr = 16'h0041;
      nack = 0;
      for (int c = 0; c < 200 && nack < 10; c++) begin
         @(negedge clk);
         if (dm_ack || if_ack) begin
            owners[nack] = dm_ack ? 1 : 0;
            chk("cont_owner", owners[nack], (nack % 5 != 4) ? 1 : 0);
            chk("cont_rdata", dm_ack ? dm_rdata : if_rdata, dm_ack ? mdl[8'h41] : mdl[8'h40]);
            if (nack == 3) chk("streak_sat", 32'(dut.u_pick.streak), STARVE);
            if (nack == 4) chk("streak_clr", 32'(dut.u_pick.streak), 0);
            nack++;
         end
      end
      chk("cont_acks", nack, 10);
      @(posedge clk); #1;
      if_req = 0; dm_req = 0;
      repeat (2) @(posedge clk);

      // Data alone never builds up streak, so a later lone fetch is served at once.
      for (int i = 0; i < 10; i++) begin
         v = '{1, (i % 2 == 0), 16'h0080 + 16'(i / 2), $urandom, 32'h0, (i % 2 == 0) ? 2 : 4};
         v.exp = v.we ? 32'h0 : mdl[v.addr[7:0]];
         if (!v.we) v.wdata = 32'h0;
         do_txn(v);
      end
      chk("fair_streak", 32'(dut.u_pick.streak), 0);
      v = '{0, 0, 16'h0081, 32'h0, 32'h0, 4};
      v.exp = mdl[8'h81];
      do_txn(v);

      // Reset in the first WAIT cycle of a fetch read.
      @(posedge clk); #1;
      if_req = 1; if_addr = 16'h0010;
      @(posedge clk);
      @(posedge clk); #2;
      rst_f = 1;
      #1;
      chk("mid_rst_busy", {31'h0, busy}, 32'h0);
      chk("mid_rst_en", {30'h0, mem_en, mem_we}, 32'h0);
      chk("mid_rst_acks", {30'h0, if_ack, dm_ack}, 32'h0);
      chk("mid_rst_regs", {16'h0, mem_addr} | mem_wdata | if_rdata | dm_rdata, 32'h0);
      if_req = 0;
      @(posedge clk); #1;
      rst_f = 0;
      saw_ack = 0;
      repeat (6) begin
         @(negedge clk);
         if (if_ack || dm_ack) saw_ack = 1;
      end
      chk("no_ack_after_rst", {31'h0, saw_ack}, 32'h0);
      v = '{0, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 4};
      do_txn(v);

      fork
         rand_if(30);
         rand_dm(30);
      join

      do_txn1(0, 16'h0044);
      do_txn1(1, 16'h0010);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
